mem_bus_arbiter: RTL

- Sequences and shares the 256x8 program/data memory and the shared 8-bit bus between two requesters.
- Requester 0 is the CPU control sequencer; requester 1 is the program loader/debug port.
- Generates the memory's address, ie and oe strobes and drives the bus for writes. Captures the bus for reads.
- Returns a one-cycle ack per completed transfer.

---
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the shared 256x8 memory and 8-bit bus: sequences IDLE/ADDR/XFER/ACK,
// round-robins simultaneous requests, drives the bus on writes and captures it on reads.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              gnt,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ie,
    output logic              mem_oe,
    inout  wire  [DATA_W-1:0] bus
);

    typedef enum logic [1:0] {IDLE, ADDR, XFER, ACK} state_t;

    localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

    state_t            r_state, w_state_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_gnt, w_gnt_nxt;
    logic [3:0]        r_wait, w_wait_nxt;
    logic              r_ie, w_ie_nxt;
    logic              r_oe, w_oe_nxt;
    logic              r_ack0, w_ack0_nxt;
    logic              r_ack1, w_ack1_nxt;
    logic              w_win;

    // Only a tie consults the last grant; a lone request always wins.
    assign w_win = (req0 && req1) ? ~r_gnt : req1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_gnt   <= 1'b1;
            r_wait  <= '0;
            r_ie    <= 1'b0;
            r_oe    <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_gnt   <= w_gnt_nxt;
            r_wait  <= w_wait_nxt;
            r_ie    <= w_ie_nxt;
            r_oe    <= w_oe_nxt;
            r_ack0  <= w_ack0_nxt;
            r_ack1  <= w_ack1_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_gnt_nxt   = r_gnt;
        w_wait_nxt  = r_wait;
        w_ie_nxt    = 1'b0;
        w_oe_nxt    = 1'b0;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_gnt_nxt   = w_win;
                    w_we_nxt    = w_win ? we1    : we0;
                    w_addr_nxt  = w_win ? addr1  : addr0;
                    w_wdata_nxt = w_win ? wdata1 : wdata0;
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                // Strobes are registered here so they are stable for the whole XFER cycle.
                w_state_nxt = XFER;
                w_ie_nxt    = r_we;
                w_oe_nxt    = ~r_we;
                w_wait_nxt  = LP_WAIT;
            end
            XFER: begin
                if (r_wait == 4'd0) begin
                    w_state_nxt = ACK;
                    w_ack0_nxt  = ~r_gnt;
                    w_ack1_nxt  = r_gnt;
                    if (!r_we) begin
                        w_rdata_nxt = bus;
                    end
                end else begin
                    w_wait_nxt = r_wait - 4'd1;
                    w_ie_nxt   = r_we;
                    w_oe_nxt   = ~r_we;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The bus is driven exactly while the write strobe is up.
    assign bus      = r_ie ? r_wdata : {DATA_W{1'bz}};
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign rdata    = r_rdata;
    assign gnt      = r_gnt;
    assign busy     = (r_state != IDLE);
    assign mem_addr = r_addr;
    assign mem_ie   = r_ie;
    assign mem_oe   = r_oe;

endmodule
